// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end with loadable memory, PC register and IDLE/RUN/HALT control
//   clock, reset        rising-edge clock, synchronous active-high reset
//   load_en/addr/data   program load port, honoured only in IDLE
//   start               IDLE->RUN or HALT->RUN restart at RESET_PC
//   stall, jump/target, branch_taken/target   PC hold and redirects while running
//   pcQ, pcD, instruction                     fetch interface to the datapath
//   valid, halted, fetch_error, cycle_count   status
module fetch_unit #(
  parameter int MEM_WORDS = 64,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          jump,
  input  logic [31:0]   jump_target,
  output logic [31:0]   pcQ,
  output logic [31:0]   pcD,
  output logic [31:0]   instruction,
  output logic          valid,
  output logic          halted,
  output logic          fetch_error,
  output logic [31:0]   cycle_count
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] pc_q, pc_d, cnt_q, cnt_d;
  logic err_q, err_d, in_range, halt_now, restart;
  assign in_range = pc_q[31:AW+2] == '0;
  assign instruction = in_range ? mem[pc_q[AW+1:2]] : 32'h0;
  // A halting cycle freezes the PC, so redirects presented with it are dropped.
  assign halt_now = state_q == RUN && (!in_range || (instruction == HALT_WORD && !stall));
  assign restart = state_q != RUN && start;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clock)
    if (state_q == IDLE && load_en) mem[load_addr] <= load_data;
  always_comb begin
    state_d = state_q == RUN ? (halt_now ? HALT : RUN) : (start ? RUN : state_q);
  end
  always_comb begin
    valid = state_q == RUN && in_range;
    halted = state_q == HALT;
  end
  always_comb begin
    pcD = (state_q != RUN || halt_now || stall) ? pc_q :
          jump ? jump_target & ~32'd3 :
          branch_taken ? branch_target & ~32'd3 : pc_q + 32'd4;
    pc_d = restart ? RESET_PC : pcD;
    cnt_d = restart ? '0 : state_q == RUN ? cnt_q + {31'd0, ~&cnt_q} : cnt_q;
    err_d = restart ? 1'b0 : err_q | (state_q == RUN && !in_range);
  end
  assign pcQ = pc_q;
  assign fetch_error = err_q;
  assign cycle_count = cnt_q;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that drives the DataPath's fetch interface: the current PC (pcQ), the next PC (pcD) and the instruction word at pcQ.
- Holds a program-loadable instruction memory and the PC register.
- Runs a small IDLE/RUN/HALT control machine so a bench can load a program, start it, and see a clean halt instead of stopping on a cycle count.
- Sits between the program loader (bench or boot logic) and the DataPath's decode/execute stage.

Parameters:
- MEM_WORDS, 64, instruction memory depth in 32-bit words; power of two.
- RESET_PC, 32'h00000000, PC value after reset and on every start.
- HALT_WORD, 32'h0000000C, instruction encoding (syscall) that halts fetch.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_en  input  1  write load_data into memory at load_addr; honoured only in IDLE.
- load_addr  input  log2(MEM_WORDS)  word address for loading.
- load_data  input  32  instruction word to load.
- start  input  1  IDLE->RUN, or HALT->RUN restart.
- stall  input  1  hold the PC this cycle.
- branch_taken  input  1  redirect to branch_target.
- branch_target  input  32  branch destination byte address.
- jump  input  1  redirect to jump_target.
- jump_target  input  32  jump destination byte address.
- pcQ  output  32  current PC (register).
- pcD  output  32  next PC (combinational).
- instruction  output  32  memory word at pcQ (combinational read).
- valid  output  1  instruction is live: RUN state and fetch in range.
- halted  output  1  in HALT state.
- fetch_error  output  1  sticky; set when pcQ is out of range.
- cycle_count  output  32  RUN cycles since the last start.

Behaviour:
- Reset (synchronous, reset high at the edge):
  - state=IDLE, pcQ=RESET_PC, fetch_error=0, cycle_count=0.
  - Memory contents are NOT cleared.
  - Reset has priority over every other input, including mid-RUN; the next cycle is IDLE with the outputs above.
- instruction:
  - Equals mem[pcQ[log2(MEM_WORDS)+1:2]] when pcQ < 4*MEM_WORDS; otherwise 32'h00000000.
  - Same-cycle combinational read; zero latency relative to pcQ.
- IDLE:
  - pcD=pcQ, valid=0.
  - load_en writes mem on the clock edge.
  - start moves to RUN with pcQ=RESET_PC and cycle_count=0.
  - load_en and start in the same cycle: the write occurs and RUN begins next cycle.
- RUN:
  - valid=1 unless pcQ is out of range.
  - pcD priority: stall -> pcQ; else jump -> {jump_target[31:2],2'b00}; else branch_taken -> {branch_target[31:2],2'b00}; else pcQ+4 (32-bit wrap).
  - pcQ<=pcD each edge.
  - cycle_count increments each RUN cycle (stalled cycles included) and saturates at 32'hFFFFFFFF.
  - load_en is ignored.
- Halt detection (RUN, at the edge):
  - instruction==HALT_WORD and stall=0 -> HALT; pcQ keeps the HALT_WORD address.
  - While stalled on HALT_WORD, stay in RUN.
  - pcQ out of range -> HALT and fetch_error=1.
  - Redirect inputs in the halting cycle are ignored.
- HALT:
  - halted=1, valid=0, pcD=pcQ, cycle_count frozen.
  - load_en is ignored.
  - start -> RUN with pcQ=RESET_PC, cycle_count=0, fetch_error=0.
- Input handling in IDLE/HALT: stall, branch_taken and jump are don't-care.
- State encoding: 2-bit state; outputs derive from state and registers with no extra output latency.

Test Plan:
- Load: mem[0]=0x20080005, mem[1]=0x20090003, mem[2]=0x0000000C via load_en, then pulse start.
  - pcQ reads 0,4,8 on consecutive cycles, with the instruction matching each word.
  - After the edge at pcQ=8: halted=1, pcQ holds 8, cycle_count=3.
- From RUN at pcQ=4, raise stall for 2 cycles.
  - pcQ stays 4 and pcD=4 for both cycles; cycle_count still increments; pcQ=8 the cycle after stall drops.
- At pcQ=0x10, assert jump=1 with jump_target=0x40, and branch_taken=1 with branch_target=0x20 in the same cycle.
  - pcD=0x40, and next-cycle pcQ=0x40 (jump wins).
  - With branch_target=0x23 alone: pcQ=0x20.
- Branch to 0x100 with MEM_WORDS=64.
  - instruction=0 and valid=0 that cycle.
  - Next cycle: halted=1, fetch_error=1.
  - start then restarts at RESET_PC with fetch_error=0.
- Assert reset at cycle 5 of RUN.
  - Next cycle: IDLE, pcQ=RESET_PC, cycle_count=0, valid=0.
  - Memory keeps its program, so start reruns it identically.
- Pulse load_en in RUN and in HALT with load_addr=0, load_data=0xFFFFFFFF.
  - mem[0] is unchanged, confirmed by the instruction value after restart.
